// File: rtl/comparator_2bit_if.sv
// Operand/result bundle for comparator_2bit; statistics signals exist only
// when COMPARATOR_2BIT_STATS_EN is defined.
interface comparator_2bit_if #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             A_eq_B;
    logic             A_lt_B;
    logic             A_gt_B;
`ifdef COMPARATOR_2BIT_STATS_EN
    logic [CNT_W-1:0] cnt_eq;
    logic [CNT_W-1:0] cnt_lt;
    logic [CNT_W-1:0] cnt_gt;
    logic             cnt_clr;

    modport master (
        output in_valid, A, B, cnt_clr,
        input  out_valid, A_eq_B, A_lt_B, A_gt_B, cnt_eq, cnt_lt, cnt_gt
    );
    modport slave (
        input  in_valid, A, B, cnt_clr,
        output out_valid, A_eq_B, A_lt_B, A_gt_B, cnt_eq, cnt_lt, cnt_gt
    );
`else
    modport master (
        output in_valid, A, B,
        input  out_valid, A_eq_B, A_lt_B, A_gt_B
    );
    modport slave (
        input  in_valid, A, B,
        output out_valid, A_eq_B, A_lt_B, A_gt_B
    );
`endif
endinterface

// File: rtl/comparator_2bit.sv
// Registered magnitude comparator with one-hot eq/lt/gt flags, 1-cycle latency.
// Optional saturating result counters under COMPARATOR_2BIT_STATS_EN.
module comparator_2bit #(
    parameter int WIDTH  = 2,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rst,
    comparator_2bit_if.slave bus
);
    if (WIDTH < 1 || WIDTH > 16 || CNT_W < 1 || $bits(bus.A) != WIDTH) begin : g_param_check
        $error("comparator_2bit: illegal WIDTH/CNT_W or interface width mismatch");
    end

    logic cmp_eq;
    logic cmp_lt;
    logic cmp_gt;
    logic eq_q;
    logic lt_q;
    logic gt_q;
    logic valid_q;

    always_comb begin
        cmp_eq = 1'b0;
        cmp_lt = 1'b0;
        if (SIGNED != 0) begin
            cmp_eq = ($signed(bus.A) == $signed(bus.B));
            cmp_lt = ($signed(bus.A) <  $signed(bus.B));
        end else begin
            cmp_eq = (bus.A == bus.B);
            cmp_lt = (bus.A <  bus.B);
        end
        cmp_gt = !cmp_eq && !cmp_lt;
    end

    // Flags only load on a valid sample, so A/B are don't-care otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            valid_q <= 1'b0;
        end else if (bus.in_valid) begin
            eq_q    <= cmp_eq;
            lt_q    <= cmp_lt;
            gt_q    <= cmp_gt;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.A_eq_B    = eq_q;
    assign bus.A_lt_B    = lt_q;
    assign bus.A_gt_B    = gt_q;
    assign bus.out_valid = valid_q;

`ifdef COMPARATOR_2BIT_STATS_EN
    logic [CNT_W-1:0] cnt_eq_q;
    logic [CNT_W-1:0] cnt_lt_q;
    logic [CNT_W-1:0] cnt_gt_q;

    // Clear wins over a same-edge increment; counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_eq_q <= '0;
            cnt_lt_q <= '0;
            cnt_gt_q <= '0;
        end else if (bus.cnt_clr) begin
            cnt_eq_q <= '0;
            cnt_lt_q <= '0;
            cnt_gt_q <= '0;
        end else if (bus.in_valid) begin
            if (cmp_eq && !(&cnt_eq_q)) cnt_eq_q <= cnt_eq_q + 1'b1;
            if (cmp_lt && !(&cnt_lt_q)) cnt_lt_q <= cnt_lt_q + 1'b1;
            if (cmp_gt && !(&cnt_gt_q)) cnt_gt_q <= cnt_gt_q + 1'b1;
        end
    end

    assign bus.cnt_eq = cnt_eq_q;
    assign bus.cnt_lt = cnt_lt_q;
    assign bus.cnt_gt = cnt_gt_q;
`endif
endmodule

// File: tb/tb_comparator_2bit.sv
// Bench for comparator_2bit: unsigned and signed instances driven in lockstep,
// directed table, hand sequences for reset/stats, then random vs a value model.
module tb_comparator_2bit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    comparator_2bit_if #(.WIDTH(2), .CNT_W(16)) bus_u ();
    comparator_2bit_if #(.WIDTH(2), .CNT_W(2))  bus_s ();

    comparator_2bit #(.WIDTH(2), .SIGNED(0), .CNT_W(16)) u_uns (.clk(clk), .rst(rst), .bus(bus_u));
    comparator_2bit #(.WIDTH(2), .SIGNED(1), .CNT_W(2))  u_sgn (.clk(clk), .rst(rst), .bus(bus_s));

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [2:0] EQ = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] GT = 3'b001;

    // Reference state: flags {eq,lt,gt}, out_valid, counters [eq,lt,gt]
    logic [2:0] m_u, m_s;
    logic       m_ov;
    int         m_cu [3];
    int         m_cs [3];
    localparam int MAX_U = 65535;
    localparam int MAX_S = 3;

    typedef struct {
        logic       v;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] exp_u;
        logic [2:0] exp_s;
    } vec_t;
    vec_t tbl [10];

    function automatic logic [2:0] ref_cmp(int x, int y);
        if (x == y) return EQ;
        if (x < y)  return LT;
        return GT;
    endfunction

    function automatic int sval(logic [1:0] v);
        return v[1] ? int'(v) - 4 : int'(v);
    endfunction

    function automatic int idx(logic [2:0] r);
        return (r == EQ) ? 0 : (r == LT) ? 1 : 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_u = '0;
        m_s = '0;
        m_ov = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_cu[i] = 0;
            m_cs[i] = 0;
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input logic [1:0] b, input logic clr);
        bus_u.in_valid = v; bus_u.A = a; bus_u.B = b;
        bus_s.in_valid = v; bus_s.A = a; bus_s.B = b;
`ifdef COMPARATOR_2BIT_STATS_EN
        bus_u.cnt_clr = clr;
        bus_s.cnt_clr = clr;
`else
        if (clr) begin end
`endif
    endtask

    // One clock with the given inputs; the model advances on the same edge.
    task automatic cycle(input logic v, input logic [1:0] a, input logic [1:0] b, input logic clr);
        logic [2:0] ru, rs;
        drive(v, a, b, clr);
        ru = ref_cmp(int'(a), int'(b));
        rs = ref_cmp(sval(a), sval(b));
        @(posedge clk);
        if (clr) begin
            for (int i = 0; i < 3; i++) begin
                m_cu[i] = 0;
                m_cs[i] = 0;
            end
        end
        if (v) begin
            m_u = ru;
            m_s = rs;
            m_ov = 1'b1;
            if (!clr) begin
                if (m_cu[idx(ru)] < MAX_U) m_cu[idx(ru)]++;
                if (m_cs[idx(rs)] < MAX_S) m_cs[idx(rs)]++;
            end
        end else begin
            m_ov = 1'b0;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".u.ov"},    32'(bus_u.out_valid), 32'(m_ov));
        chk({tag, ".s.ov"},    32'(bus_s.out_valid), 32'(m_ov));
        chk({tag, ".u.flags"}, 32'({bus_u.A_eq_B, bus_u.A_lt_B, bus_u.A_gt_B}), 32'(m_u));
        chk({tag, ".s.flags"}, 32'({bus_s.A_eq_B, bus_s.A_lt_B, bus_s.A_gt_B}), 32'(m_s));
`ifdef COMPARATOR_2BIT_STATS_EN
        chk({tag, ".u.cnt_eq"}, 32'(bus_u.cnt_eq), 32'(m_cu[0]));
        chk({tag, ".u.cnt_lt"}, 32'(bus_u.cnt_lt), 32'(m_cu[1]));
        chk({tag, ".u.cnt_gt"}, 32'(bus_u.cnt_gt), 32'(m_cu[2]));
        chk({tag, ".s.cnt_eq"}, 32'(bus_s.cnt_eq), 32'(m_cs[0]));
        chk({tag, ".s.cnt_lt"}, 32'(bus_s.cnt_lt), 32'(m_cs[1]));
        chk({tag, ".s.cnt_gt"}, 32'(bus_s.cnt_gt), 32'(m_cs[2]));
`endif
    endtask

    initial begin
        tbl[0] = '{1'b1, 2'b00, 2'b00, EQ, EQ};
        tbl[1] = '{1'b1, 2'b01, 2'b00, GT, GT};
        tbl[2] = '{1'b1, 2'b10, 2'b11, LT, LT};
        tbl[3] = '{1'b1, 2'b11, 2'b10, GT, GT};
        tbl[4] = '{1'b1, 2'b11, 2'b11, EQ, EQ};
        tbl[5] = '{1'b1, 2'b01, 2'b10, LT, GT};
        tbl[6] = '{1'b0, 2'b11, 2'b00, LT, GT};
        tbl[7] = '{1'b1, 2'b10, 2'b01, GT, LT};
        tbl[8] = '{1'b1, 2'b11, 2'b10, GT, GT};
        tbl[9] = '{1'b1, 2'b11, 2'b11, EQ, EQ};

        model_reset();
        drive(1'b0, 2'b00, 2'b00, 1'b0);

        // Reset state, then idle cycles stay zero
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        chk("reset.u.flags0", 32'({bus_u.A_eq_B, bus_u.A_lt_B, bus_u.A_gt_B}), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 2'(i), 2'(i + 1), 1'b0);
            check_model("idle");
        end

        // Directed table, both arithmetic modes
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].v, tbl[i].a, tbl[i].b, 1'b0);
            chk($sformatf("tbl%0d.ov", i), 32'(bus_u.out_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d.u", i), 32'({bus_u.A_eq_B, bus_u.A_lt_B, bus_u.A_gt_B}), 32'(tbl[i].exp_u));
            chk($sformatf("tbl%0d.s", i), 32'({bus_s.A_eq_B, bus_s.A_lt_B, bus_s.A_gt_B}), 32'(tbl[i].exp_s));
        end
        check_model("tbl_end");

        // Async reset between edges; a sample held during reset is dropped
        cycle(1'b1, 2'b01, 2'b10, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("async_rst.ov", 32'(bus_u.out_valid), 32'd0);
        chk("async_rst.u", 32'({bus_u.A_eq_B, bus_u.A_lt_B, bus_u.A_gt_B}), 32'd0);
        chk("async_rst.s", 32'({bus_s.A_eq_B, bus_s.A_lt_B, bus_s.A_gt_B}), 32'd0);
        drive(1'b1, 2'b11, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_discard.ov", 32'(bus_u.out_valid), 32'd0);
        chk("rst_discard.u", 32'({bus_u.A_eq_B, bus_u.A_lt_B, bus_u.A_gt_B}), 32'd0);
        drive(1'b0, 2'b00, 2'b00, 1'b0);
        rst = 1'b0;
        model_reset();
        cycle(1'b0, 2'b00, 2'b00, 1'b0);
        check_model("post_rst");

`ifdef COMPARATOR_2BIT_STATS_EN
        // Counts from the five-vector unsigned run, then clear beats increment
        for (int i = 0; i < 5; i++) cycle(tbl[i].v, tbl[i].a, tbl[i].b, 1'b0);
        chk("stats.cnt_eq", 32'(bus_u.cnt_eq), 32'd2);
        chk("stats.cnt_lt", 32'(bus_u.cnt_lt), 32'd1);
        chk("stats.cnt_gt", 32'(bus_u.cnt_gt), 32'd2);
        cycle(1'b1, 2'b00, 2'b00, 1'b1);
        chk("clr.cnt_eq", 32'(bus_u.cnt_eq), 32'd0);
        chk("clr.cnt_lt", 32'(bus_u.cnt_lt), 32'd0);
        chk("clr.cnt_gt", 32'(bus_u.cnt_gt), 32'd0);
        check_model("clr");
`endif

        // Random traffic; operands are garbage whenever in_valid is low
        for (int i = 0; i < 400; i++) begin
            logic v, clr;
            logic [1:0] a, b;
            v   = ($urandom % 4) != 0;
            a   = v ? 2'($urandom) : 2'bxx;
            b   = v ? 2'($urandom) : 2'bxx;
            clr = ($urandom % 32) == 0;
            cycle(v, a, b, clr);
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end
endmodule
